// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and presents the difference, borrow-out and signed overflow as registered outputs.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] di,
    output logic             ba,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic x;
    logic y;
    logic d;
    logic br_next;
    logic last_bit;
    logic accept;

    // Full-subtractor slice on the current LSBs of the operand shift registers.
    always_comb begin
        x        = a_sr[0];
        y        = b_sr[0];
        d        = x ^ y ^ br;
        br_next  = (~x & y) | (~(x ^ y) & br);
        last_bit = (cnt == CNT_W'(WIDTH - 1));
        accept   = start && (state != RUN);
    end

    // NOTE: every signal written here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            di     <= '0;
            ba     <= 1'b0;
            ovf    <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (accept) begin
                a_sr <= a;
                b_sr <= b;
                br   <= bin;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                br     <= br_next;
                res_sr <= {d, res_sr[WIDTH-1:1]};
                cnt    <= cnt + 1'b1;
                // Final bit: the borrow entering it and the one leaving it give ovf.
                if (last_bit) begin
                    di  <= {d, res_sr[WIDTH-1:1]};
                    ba  <= br_next;
                    ovf <= br ^ br_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: a driver issues starts and queues expected
// results from an arithmetic model; a monitor checks every done pulse and busy.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] di;
    logic         ba;
    logic         ovf;

    serial_sub #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .di   (di),
        .ba   (ba),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] di;
        logic         ba;
        logic         ovf;
        int           done_edge;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           n_accept = 0;
    int           n_done = 0;
    int           last_accept = -1000;
    int           next_free = 0;
    bit           mon_en = 1'b0;
    logic [W-1:0] hold_di = '0;
    logic         hold_ba = 1'b0;
    logic         hold_ovf = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic bv_in, input int edge_n);
        exp_t   e;
        longint ua, ub, sa, sbv, diff, sd;
        ua   = longint'(av);
        ub   = longint'(bv);
        sa   = av[W-1] ? ua - (longint'(1) << W) : ua;
        sbv  = bv[W-1] ? ub - (longint'(1) << W) : ub;
        diff = ua - ub - longint'(bv_in);
        sd   = sa - sbv - longint'(bv_in);
        e.di        = diff[W-1:0];
        e.ba        = (ua < ub + longint'(bv_in));
        e.ovf       = (sd < -(longint'(1) << (W - 1))) || (sd > (longint'(1) << (W - 1)) - 1);
        e.done_edge = edge_n + W;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // One cycle of stimulus; the start is accepted only when no operation occupies the edge.
    task automatic drive(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic bv_in);
        int e;
        @(negedge clk);
        start = st;
        a     = av;
        b     = bv;
        bin   = bv_in;
        e     = cyc + 1;
        if (st && e >= next_free) begin
            sb.push_back(model(av, bv, bv_in, e));
            n_accept++;
            last_accept = e;
            next_free   = e + W + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        start       = 1'b0;
        sb.delete();
        last_accept = -1000;
        next_free   = cyc + 2;
        hold_di     = '0;
        hold_ba     = 1'b0;
        hold_ovf    = 1'b0;
        @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_di", di, 0);
        check("rst_ba", ba, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    // Monitor: busy/done timing from the accept history, results from the queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && !rst) begin
                check("busy", busy, (cyc >= last_accept && cyc <= last_accept + W - 1) ? 1 : 0);
                check("busy_done_excl", busy & done, 0);
                if (done) begin
                    n_done++;
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("done_edge", cyc, e.done_edge);
                        check("di", di, e.di);
                        check("ba", ba, e.ba);
                        check("ovf", ovf, e.ovf);
                        hold_di  = e.di;
                        hold_ba  = e.ba;
                        hold_ovf = e.ovf;
                    end
                end else begin
                    check("hold_di", di, hold_di);
                    check("hold_flags", {ba, ovf}, {hold_ba, hold_ovf});
                    if (sb.size() > 0 && cyc >= sb[0].done_edge) begin
                        check("done_missing", cyc, sb[0].done_edge - 1);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] corner[5];
        corner[0] = '0;
        corner[1] = '1;
        corner[2] = {1'b1, {(W-1){1'b0}}};
        corner[3] = {1'b0, {(W-1){1'b1}}};
        corner[4] = 8'h01;

        repeat (2) @(negedge clk);
        do_reset();

        // Directed vectors, including the equal, zero and sign-boundary cases.
        drive(1'b1, 8'h05, 8'h03, 1'b0); idle(W + 2);
        drive(1'b1, 8'h00, 8'h01, 1'b0); idle(W + 2);
        drive(1'b1, 8'h03, 8'h03, 1'b1); idle(W + 2);
        drive(1'b1, 8'h80, 8'h01, 1'b0); idle(W + 2);
        drive(1'b1, 8'h7F, 8'hFF, 1'b0); idle(W + 2);
        drive(1'b1, 8'h00, 8'hFF, 1'b1); idle(W + 2);

        // Start held high with changing operands: ignored in RUN, back-to-back from DONE.
        drive(1'b1, 8'h10, 8'h01, 1'b0);
        for (int i = 0; i < 2 * W + 2; i++) drive(1'b1, 8'hC3 + 8'(i), 8'h5A, 1'b1);
        idle(W + 3);

        // Abort mid-operation: no done pulse may follow.
        drive(1'b1, 8'h44, 8'h11, 1'b0);
        idle(3);
        do_reset();
        idle(W + 4);

        // Immediate start on the first edge after reset.
        drive(1'b1, 8'h22, 8'h33, 1'b0); idle(W + 2);

        // Randomised operations with random gaps, including back-to-back.
        while (n_accept < 1020) begin
            logic [W-1:0] av, bv;
            av = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            bv = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            drive($urandom_range(0, 3) != 0, av, bv, 1'($urandom));
        end

        idle(2 * W + 4);
        check("queue_drained", sb.size(), 0);
        check("done_count", n_done, n_accept - 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
